jtframe_prog_loader: RTL

//  Consumer of the SPI ROM-download byte stream (ioctl_addr/ioctl_data/ioctl_wr) from the MiST base.

---
 rtl/jtframe_prog_loader.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/jtframe_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : jtframe_prog_loader
// Purpose  : Accepts the ROM-download byte stream coming from the base
//            (ioctl_*) and replays it as SDRAM programming writes (prog_*).
//            Bytes are buffered in a small FIFO so the base never waits on
//            the SDRAM controller. Each write is held until prog_rdy accepts
//            it. dwnld_busy stays high until the final byte is committed.
// Ports    :
//   clk_rom      in   SDRAM clock, all logic on its rising edge
//   rst          in   synchronous active-high reset
//   downloading  in   download window from the base
//   ioctl_addr   in   [AW-1:0] byte address of incoming byte
//   ioctl_data   in   [7:0] incoming byte
//   ioctl_wr     in   one-cycle strobe, byte valid
//   prog_addr    out  [AW-1:0] 16-bit word address {1'b0, byte_addr[AW-1:1]}
//   prog_data    out  [7:0] byte to write
//   prog_mask    out  [1:0] active-low byte-lane enables
//   prog_we      out  write request, held until accepted
//   prog_rdy     in   controller accepts current write when high at an edge
//   dwnld_busy   out  high while any download work is pending
//   overflow     out  sticky, a byte was dropped on a full FIFO
// Revision : 1.0 - initial release
// ============================================================================
module jtframe_prog_loader #(
    parameter int AW      = 22,
    parameter int FIFO_AW = 2,
    parameter int SWAB    = 0
) (
    input  logic          clk_rom,
    input  logic          rst,
    input  logic          downloading,
    input  logic [AW-1:0] ioctl_addr,
    input  logic [7:0]    ioctl_data,
    input  logic          ioctl_wr,
    output logic [AW-1:0] prog_addr,
    output logic [7:0]    prog_data,
    output logic [1:0]    prog_mask,
    output logic          prog_we,
    input  logic          prog_rdy,
    output logic          dwnld_busy,
    output logic          overflow
);

    localparam int              c_DEPTH   = 1 << FIFO_AW;
    localparam int              c_EW      = AW + 8;
    localparam logic            c_SWAB    = (SWAB != 0);
    localparam logic [FIFO_AW:0] c_PTR_ONE = {{FIFO_AW{1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    state_t              state_q;
    logic [c_EW-1:0]     fifo_q [c_DEPTH];
    logic [FIFO_AW:0]    wr_ptr_q;
    logic [FIFO_AW:0]    rd_ptr_q;
    logic [FIFO_AW:0]    wr_ptr_d;
    logic [FIFO_AW:0]    rd_ptr_d;
    logic                downloading_q;
    logic                overflow_q;
    logic                overflow_d;
    logic                busy_q;
    logic                prog_we_q;
    logic [AW-1:0]       prog_addr_q;
    logic [7:0]          prog_data_q;
    logic [1:0]          prog_mask_q;

    logic                fifo_empty;
    logic                fifo_full;
    logic                accept;
    logic                pop;
    logic                push_req;
    logic                push;
    logic                drop;
    logic [c_EW-1:0]     head;
    logic [AW-1:0]       head_addr;
    logic [7:0]          head_data;
    logic [AW-1:0]       head_word;
    logic [1:0]          head_mask;

    // Pointers carry one extra wrap bit: equal pointers mean empty, pointers
    // that differ only in the wrap bit mean full.
    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                     (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
        accept     = (state_q == S_WRITE) && prog_rdy;
        // Pop either to start a write from IDLE or to chain the next write
        // on the very edge the current one is accepted.
        pop        = !fifo_empty && ((state_q == S_IDLE) || accept);
        push_req   = ioctl_wr && downloading;
        // A simultaneous pop frees a slot, so a full FIFO can still accept.
        push       = push_req && (!fifo_full || pop);
        drop       = push_req && fifo_full && !pop;

        wr_ptr_d   = push ? (wr_ptr_q + c_PTR_ONE) : wr_ptr_q;
        rd_ptr_d   = pop  ? (rd_ptr_q + c_PTR_ONE) : rd_ptr_q;

        // Overflow is sticky for the whole download; a new download window
        // starts clean. A drop on that same edge still wins.
        overflow_d = overflow_q;
        if (downloading && !downloading_q) begin
            overflow_d = 1'b0;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end

        head       = fifo_q[rd_ptr_q[FIFO_AW-1:0]];
        head_addr  = head[c_EW-1:8];
        head_data  = head[7:0];
        head_word  = {1'b0, head_addr[AW-1:1]};
        // Even byte goes to the low lane (mask 2'b10) unless lanes are swapped.
        head_mask  = (head_addr[0] ^ c_SWAB) ? 2'b01 : 2'b10;
    end

    // FIFO storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk_rom) begin
        if (push) begin
            fifo_q[wr_ptr_q[FIFO_AW-1:0]] <= {ioctl_addr, ioctl_data};
        end
    end

    always_ff @(posedge clk_rom) begin
        if (rst) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            downloading_q <= 1'b0;
            overflow_q    <= 1'b0;
            busy_q        <= 1'b0;
            prog_we_q     <= 1'b0;
            prog_addr_q   <= '0;
            prog_data_q   <= '0;
            prog_mask_q   <= 2'b11;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            downloading_q <= downloading;
            overflow_q    <= overflow_d;
            busy_q        <= downloading | !fifo_empty | prog_we_q;

            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        prog_addr_q <= head_word;
                        prog_data_q <= head_data;
                        prog_mask_q <= head_mask;
                        prog_we_q   <= 1'b1;
                        state_q     <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    // No timeout: the request is held for as long as the
                    // controller keeps prog_rdy low.
                    if (accept) begin
                        if (pop) begin
                            prog_addr_q <= head_word;
                            prog_data_q <= head_data;
                            prog_mask_q <= head_mask;
                        end else begin
                            prog_we_q   <= 1'b0;
                            state_q     <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    prog_we_q <= 1'b0;
                end
            endcase
        end
    end

    assign prog_addr  = prog_addr_q;
    assign prog_data  = prog_data_q;
    assign prog_mask  = prog_mask_q;
    assign prog_we    = prog_we_q;
    assign dwnld_busy = busy_q;
    assign overflow   = overflow_q;

endmodule
`default_nettype wire
